// File: rtl/sw2_buf.sv
// sw2_buf: buffered 2x2 banyan switching element.
// Each input word is steered by bit 0 of its destination tag into one of two
// per-output FIFOs; the tag is shifted right for the next fabric stage.
// Contention for one output is resolved by a per-output round-robin pointer,
// and a full FIFO refuses input (no push-through on a simultaneous pop).
module sw2_buf #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 2,
  parameter int DEPTH  = 4,
  parameter int LWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] din0,
  input  logic [DWIDTH-1:0] din1,
  input  logic [AWIDTH-1:0] dst_in0,
  input  logic [AWIDTH-1:0] dst_in1,
  input  logic              in_vld0,
  input  logic              in_vld1,
  output logic              in_rdy0,
  output logic              in_rdy1,
  output logic [DWIDTH-1:0] dout0,
  output logic [DWIDTH-1:0] dout1,
  output logic [AWIDTH-1:0] dst_out0,
  output logic [AWIDTH-1:0] dst_out1,
  output logic              out_vld0,
  output logic              out_vld1,
  input  logic              out_rdy0,
  input  logic              out_rdy1,
  output logic [LWIDTH-1:0] lvl0,
  output logic [LWIDTH-1:0] lvl1
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = DWIDTH + AWIDTH;

  // Tag presented to the next stage: consumed routing bit dropped, MSB zeroed.
  function automatic logic [AWIDTH-1:0] shift_tag(input logic [AWIDTH-1:0] t);
    return t >> 1;
  endfunction

  logic [1:0]        req0, req1;   // reqN[k]: input N requests output k
  logic [1:0]        g0, g1;       // gN[k]:   input N granted to output k
  logic [1:0]        blocked;
  logic [1:0]        out_rdy;
  logic [1:0]        out_vld;
  logic [1:0]        rr_q, rr_d;
  logic [LWIDTH-1:0] lvl [2];
  logic [WW-1:0]     head [2];
  logic [WW-1:0]     word0, word1;

  assign req0    = {in_vld0 &  dst_in0[0], in_vld0 & ~dst_in0[0]};
  assign req1    = {in_vld1 &  dst_in1[0], in_vld1 & ~dst_in1[0]};
  assign out_rdy = {out_rdy1, out_rdy0};
  assign word0   = {din0, shift_tag(dst_in0)};
  assign word1   = {din1, shift_tag(dst_in1)};

  // Per-output arbitration: single requester wins outright, two requesters
  // are settled by rr, which flips only on such a contended grant.
  always_comb begin
    g0   = '0;
    g1   = '0;
    rr_d = rr_q;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (!blocked[k]) begin
          if (req0[k] && req1[k]) begin
            if (rr_q[k]) g1[k] = 1'b1;
            else         g0[k] = 1'b1;
            rr_d[k] = ~rr_q[k];
          end else begin
            g0[k] = req0[k];
            g1[k] = req1[k];
          end
        end
      end
    end
  end

  assign in_rdy0 = |g0;
  assign in_rdy1 = |g1;

  // Round-robin pointers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [WW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic              push, pop;

    assign push = g0[k] | g1[k];
    assign pop  = (cnt_q != '0) && out_rdy[k];

    // Occupancy next state; simultaneous push and pop leaves it unchanged.
    always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + LWIDTH'(1);
        2'b01:   cnt_d = cnt_q - LWIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // FIFO control: pointers wrap naturally, occupancy tracked by cnt.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
      end
    end

    // Storage is deliberately left out of reset; out_vld masks stale data.
    always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= g0[k] ? word0 : word1;
    end

    assign blocked[k] = (cnt_q == LWIDTH'(DEPTH));
    assign lvl[k]     = cnt_q;
    assign head[k]    = mem[rd_q];
    assign out_vld[k] = (cnt_q != '0);
  end

  assign dout0    = head[0][WW-1:AWIDTH];
  assign dst_out0 = head[0][AWIDTH-1:0];
  assign dout1    = head[1][WW-1:AWIDTH];
  assign dst_out1 = head[1][AWIDTH-1:0];
  assign out_vld0 = out_vld[0];
  assign out_vld1 = out_vld[1];
  assign lvl0     = lvl[0];
  assign lvl1     = lvl[1];

endmodule

// File: doc/sw2_buf.md
# sw2_buf

Buffered 2x2 banyan switching element with valid/ready flow control, the successor to the unbuffered 2x2 element in the banyan fabric. Each input word is routed by bit 0 of its destination tag to one of two outputs, and the tag is shifted right by one for the next stage. Unlike the unbuffered element, it resolves output contention with per-output round-robin arbitration and absorbs bursts in a per-output FIFO. Upstream backpressure is applied through in_rdy, so stages can be chained without a conflict-free routing guarantee.

## Interface
Parameters:
- DWIDTH, 8, payload width.
- AWIDTH, 2, destination tag width; must be >= 1.
- DEPTH, 4, entries per output FIFO; must be a power of 2 and >= 2.
- LWIDTH, $clog2(DEPTH+1), width of the occupancy outputs (derived; do not override).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- din0 / din1  in  DWIDTH  input payload.
- dst_in0 / dst_in1  in  AWIDTH  destination tag; bit 0 selects the output.
- in_vld0 / in_vld1  in  1  input valid.
- in_rdy0 / in_rdy1  out  1  input accepted this cycle; combinational.
- dout0 / dout1  out  DWIDTH  output payload, taken from the FIFO head.
- dst_out0 / dst_out1  out  AWIDTH  shifted tag, {1'b0, dst_in[AWIDTH-1:1]}.
- out_vld0 / out_vld1  out  1  output valid (FIFO not empty).
- out_rdy0 / out_rdy1  in  1  downstream ready.
- lvl0 / lvl1  out  LWIDTH  current FIFO occupancy, 0..DEPTH.

## Operation
Routing and arbitration:
- Input i requests output k when in_vld_i = 1 and dst_in_i[0] = k.
- Output k is blocked when lvl_k == DEPTH. No push-through-on-pop: a full FIFO refuses input even if it pops in the same cycle.
- If output k has a single requester and is not blocked, that requester is granted.
- If output k has two requesters and is not blocked, input rr_k is granted, the other input is refused, and rr_k toggles.
- rr_k changes only on a contended grant.
- in_rdy_i = 1 exactly when input i is granted. It is 0 whenever in_vld_i = 0 or rst = 1.
- A refused input must hold din, dst_in and in_vld until it is accepted (standard valid/ready). in_vld must never depend on in_rdy.
- Inputs targeting different outputs are both accepted in the same cycle if neither FIFO is full.

FIFO behaviour:
- On a grant, the FIFO stores {din, shifted tag}.
- Pop occurs when out_vld_k && out_rdy_k.
- Push and pop can happen together: lvl_k stays the same and the pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally; occupancy is tracked by the lvl counter.
- Ordering is FIFO per output. Words from the same input to the same output never reorder.

Reset (rst = 1 at a clock edge):
- lvl0 = lvl1 = 0, out_vld0 = out_vld1 = 0, rr0 = rr1 = 0, and pointers = 0.
- Any FIFO contents are discarded, including when reset arrives mid-burst.
- Storage is not reset. dout and dst_out are don't-care while out_vld = 0.

## Timing
- in_rdy is combinational from in_vld0/1, dst_in0/1[0], lvl and rr. There is no path from out_rdy to in_rdy.
- Latency: a word accepted at edge N appears on dout with out_vld = 1 after edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput is 1 word per output per cycle, and 2 words per cycle in aggregate with no contention.
- lvl and out_vld update on the edge after the push or pop.
- Under sustained contention on one output with out_rdy held high, grants alternate 0,1,0,1 starting from the rr value.

## Test plan
- Reset, then in_vld0 = 1 with dst_in0 = 2'b01 and din0 = 8'hA5, out_rdy1 = 1 -> in_rdy0 = 1 in cycle 0; cycle 1 shows out_vld1 = 1, dout1 = 8'hA5, dst_out1 = 2'b00, and lvl1 = 1; after the pop, lvl1 = 0.
- Both inputs valid targeting output 0 (din0 = 8'h11, din1 = 8'h22), held for 4 cycles, out_rdy0 = 1 -> in_rdy grants 0,1,0,1; dout0 sequence is 11,22,11,22 starting the cycle after the first grant.
- Input 0 to output 0 and input 1 to output 1 in the same cycle -> both in_rdy = 1; both outputs are valid next cycle with the correct payloads.
- out_rdy0 = 0, and 5 words are sent to output 0 with DEPTH = 4 -> the first 4 are accepted and lvl0 reaches 4, then in_rdy0 = 0 with lvl0 = 4; raising out_rdy0 drains 4 words in order, and the 5th is accepted the cycle after lvl0 drops to 3.
- Full FIFO with pop and push in the same cycle -> the push is refused (in_rdy = 0) and lvl drops to 3.
- Assert rst for 1 cycle while lvl0 = 3 -> after the edge, lvl0 = 0, out_vld0 = 0, rr0 = 0, and in_rdy = 0 during rst; normal operation resumes the following cycle.
